// File: rtl/cbz_branch_ctrl.sv
// cbz_branch_ctrl: decode-stage CBZ/B.cond/B resolution with hazard stalls and branch statistics
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   id_valid, id_is_cbz,
//   id_is_bcond, id_is_b, id_rt branch instruction in ID and the register CBZ tests
//   ex_regwrite, ex_memread,
//   ex_rd, ex_setflags          producer in EX (register write, load, flag set)
//   mem_memread, mem_rd         load in MEM
//   cbz_zero, cond_true         forwarded zero flag of Rt, B.cond evaluation
//   stall_if_id, bubble_id_ex   hold IF/ID, insert NOP into ID/EX
//   take_branch, flush_if       redirect PC to target, kill wrong-path fetch
//   busy                        controller is waiting on a hazard
//   taken_cnt, nottaken_cnt,
//   stall_cnt                   saturating statistics
module cbz_branch_ctrl #(
    parameter int CNT_W = 32,
    parameter int XZR   = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_is_cbz,
    input  logic             id_is_bcond,
    input  logic             id_is_b,
    input  logic [4:0]       id_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_setflags,
    input  logic             mem_memread,
    input  logic [4:0]       mem_rd,
    input  logic             cbz_zero,
    input  logic             cond_true,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic             take_branch,
    output logic             flush_if,
    output logic             busy,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] taken_q, taken_d, nottaken_q, nottaken_d, stall_q, stall_d;
    logic             br, rt_ok, ex_hit, mem_hit, taken, idle, resolve, stall;
    logic [1:0]       need;

    always_comb begin
        br      = id_valid & (id_is_cbz | id_is_bcond | id_is_b);
        rt_ok   = id_rt != 5'(XZR);
        ex_hit  = ex_regwrite & (ex_rd == id_rt) & rt_ok;
        mem_hit = mem_memread & (mem_rd == id_rt) & rt_ok;
        // EX is checked first: the younger producer determines the wait
        need    = id_is_cbz   ? (ex_hit ? (ex_memread ? 2'd2 : 2'd1) : (mem_hit ? 2'd1 : 2'd0)) :
                  id_is_bcond ? {1'b0, ex_setflags} : 2'd0;
        taken   = id_is_b | (id_is_cbz & cbz_zero) | (id_is_bcond & cond_true);
        idle    = state_q == IDLE;
        // br carries id_valid, so an external flush in WAIT/RESOLVE suppresses both
        resolve = !reset & br & (idle ? need == 2'd0 : state_q == RESOLVE);
        stall   = !reset & br & (idle ? need != 2'd0 : state_q == WAIT);
        state_d = (idle & br & need != 2'd0) ? (need == 2'd1 ? RESOLVE : WAIT) :
                  (state_q == WAIT & br)     ? (cnt_q <= 2'd1 ? RESOLVE : WAIT) : IDLE;
        cnt_d   = (idle & br & need != 2'd0) ? need - 2'd1 :
                  (state_q == WAIT & br)     ? cnt_q - 2'd1 : cnt_q;
        taken_d    = (resolve & taken & ~&taken_q)     ? taken_q + CNT_W'(1)    : taken_q;
        nottaken_d = (resolve & !taken & ~&nottaken_q) ? nottaken_q + CNT_W'(1) : nottaken_q;
        stall_d    = (stall & ~&stall_q)               ? stall_q + CNT_W'(1)    : stall_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            taken_q    <= '0;
            nottaken_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            taken_q    <= taken_d;
            nottaken_q <= nottaken_d;
            stall_q    <= stall_d;
        end
    end

    assign stall_if_id  = stall;
    assign bubble_id_ex = stall;
    assign take_branch  = resolve & taken;
    assign flush_if     = resolve & taken;
    assign busy         = state_q != IDLE;
    assign taken_cnt    = taken_q;
    assign nottaken_cnt = nottaken_q;
    assign stall_cnt    = stall_q;
endmodule

// File: tb/tb_cbz_branch_ctrl.sv
// tb_cbz_branch_ctrl: scoreboard bench for cbz_branch_ctrl
module tb_cbz_branch_ctrl;
    logic        clk = 0, reset = 1;
    logic        id_valid = 0, id_is_cbz = 0, id_is_bcond = 0, id_is_b = 0;
    logic [4:0]  id_rt = 0, ex_rd = 0, mem_rd = 0;
    logic        ex_regwrite = 0, ex_memread = 0, ex_setflags = 0, mem_memread = 0;
    logic        cbz_zero = 0, cond_true = 0;
    logic        stall_if_id, bubble_id_ex, take_branch, flush_if, busy;
    logic [31:0] taken_cnt, nottaken_cnt, stall_cnt;

    cbz_branch_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_cbz(id_is_cbz),
        .id_is_bcond(id_is_bcond), .id_is_b(id_is_b), .id_rt(id_rt),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_setflags(ex_setflags), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .cbz_zero(cbz_zero), .cond_true(cond_true), .stall_if_id(stall_if_id),
        .bubble_id_ex(bubble_id_ex), .take_branch(take_branch), .flush_if(flush_if),
        .busy(busy), .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall, take, busy;
        logic [31:0] tc, nc, sc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_pass = 0;
    logic [31:0] m_tc = 0, m_nc = 0, m_sc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // one clock of stimulus; es/er/et/eb = expected stall, resolve, taken, busy
    task automatic cyc(input string tag, input logic v, cbz, bc, b, input logic [4:0] rt,
                       input logic exrw, exmr, input logic [4:0] exrd, input logic exsf,
                       input logic memmr, input logic [4:0] memrd, input logic z, ct,
                       input logic es, er, et, eb);
        @(posedge clk);
        #1;
        id_valid = v; id_is_cbz = cbz; id_is_bcond = bc; id_is_b = b; id_rt = rt;
        ex_regwrite = exrw; ex_memread = exmr; ex_rd = exrd; ex_setflags = exsf;
        mem_memread = memmr; mem_rd = memrd; cbz_zero = z; cond_true = ct;
        sb.push_back('{tag, es, er & et, eb, m_tc, m_nc, m_sc});
        m_tc += 32'(er & et);
        m_nc += 32'(er & !et);
        m_sc += 32'(es);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, " stall"}, 32'(stall_if_id), 32'(e.stall));
            chk({e.tag, " bubble"}, 32'(bubble_id_ex), 32'(e.stall));
            chk({e.tag, " take"}, 32'(take_branch), 32'(e.take));
            chk({e.tag, " flush"}, 32'(flush_if), 32'(e.take));
            chk({e.tag, " busy"}, 32'(busy), 32'(e.busy));
            chk({e.tag, " taken_cnt"}, taken_cnt, e.tc);
            chk({e.tag, " nottaken_cnt"}, nottaken_cnt, e.nc);
            chk({e.tag, " stall_cnt"}, stall_cnt, e.sc);
        end
    end

    initial begin
        // reset held with an unconditional B presented: every output must stay 0
        id_valid = 1; id_is_b = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst take", 32'(take_branch), 0);
        chk("rst flush", 32'(flush_if), 0);
        chk("rst stall", 32'(stall_if_id), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst cnt", taken_cnt | nottaken_cnt | stall_cnt, 0);
        id_valid = 0; id_is_b = 0;
        reset = 0;
        //   tag          v cbz bc b rt  exrw exmr exrd exsf mmr mrd z ct  es er et eb
        cyc("idle",       0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0);
        cyc("cbz nohaz",  1, 1, 0, 0, 3,  0, 0, 0,  0, 0, 0,  1, 0,  0, 1, 1, 0);
        cyc("add-cbz a",  1, 1, 0, 0, 3,  1, 0, 3,  0, 0, 0,  0, 0,  1, 0, 0, 0);
        cyc("add-cbz b",  1, 1, 0, 0, 3,  0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0, 1);
        cyc("ldur-cbz a", 1, 1, 0, 0, 3,  1, 1, 3,  0, 0, 0,  1, 0,  1, 0, 0, 0);
        cyc("ldur-cbz b", 1, 1, 0, 0, 3,  1, 1, 3,  0, 0, 0,  1, 0,  1, 0, 0, 1);
        cyc("ldur-cbz c", 1, 1, 0, 0, 3,  0, 0, 0,  0, 0, 0,  1, 0,  0, 1, 1, 1);
        cyc("cbz xzr",    1, 1, 0, 0, 31, 1, 1, 31, 0, 1, 31, 1, 0,  0, 1, 1, 0);
        cyc("mem-cbz a",  1, 1, 0, 0, 5,  0, 0, 0,  0, 1, 5,  0, 0,  1, 0, 0, 0);
        cyc("mem-cbz b",  1, 1, 0, 0, 5,  0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0, 1);
        cyc("ex+mem a",   1, 1, 0, 0, 7,  1, 1, 7,  0, 1, 7,  0, 0,  1, 0, 0, 0);
        cyc("ex+mem b",   1, 1, 0, 0, 7,  1, 1, 7,  0, 1, 7,  0, 0,  1, 0, 0, 1);
        cyc("ex+mem c",   1, 1, 0, 0, 7,  0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0, 1);
        cyc("ex other rd",1, 1, 0, 0, 3,  1, 1, 4,  0, 0, 0,  0, 0,  0, 1, 0, 0);
        cyc("subs-bc a",  1, 0, 1, 0, 0,  1, 0, 2,  1, 0, 0,  0, 1,  1, 0, 0, 0);
        cyc("subs-bc b",  1, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1,  0, 1, 1, 1);
        cyc("bc nohaz",   1, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0, 0);
        cyc("b",          1, 0, 0, 1, 3,  1, 1, 3,  1, 1, 3,  0, 0,  0, 1, 1, 0);
        cyc("flush a",    1, 1, 0, 0, 9,  1, 0, 9,  0, 0, 0,  1, 0,  1, 0, 0, 0);
        cyc("flush b",    0, 1, 0, 0, 9,  0, 0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 1);
        cyc("flush c",    0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0);
        cyc("rstwait a",  1, 1, 0, 0, 3,  1, 1, 3,  0, 0, 0,  0, 0,  1, 0, 0, 0);
        cyc("rstwait b",  1, 1, 0, 0, 3,  1, 1, 3,  0, 0, 0,  0, 0,  1, 0, 0, 1);
        // async reset while WAIT: outputs and counters clear without a clock edge
        @(posedge clk);
        #1;
        reset = 1;
        #1;
        chk("midrst stall", 32'(stall_if_id), 0);
        chk("midrst take", 32'(take_branch), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst taken_cnt", taken_cnt, 0);
        chk("midrst nottaken_cnt", nottaken_cnt, 0);
        chk("midrst stall_cnt", stall_cnt, 0);
        @(posedge clk);
        #1;
        reset = 0; id_valid = 0; id_is_cbz = 0; ex_regwrite = 0; ex_memread = 0;
        m_tc = 0; m_nc = 0; m_sc = 0;
        cyc("post rst",   0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0);
        cyc("post b",     1, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 1, 0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) chk("scoreboard drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
